// File: rtl/mat_pkg.sv
// Shared types and sizing for the 6x6 matrix multiplier loader.
// Elements are fixed-point words passed through unchanged.
package mat_pkg;

    localparam int N            = 6;
    localparam int W            = 27;
    localparam int RUN_CYCLES   = 12;
    localparam int DRAIN_CYCLES = 2;
    localparam int IW           = 3;

    typedef logic [W-1:0]          elem_t;
    typedef elem_t [N-1:0][N-1:0]  mat_t;
    typedef logic [IW-1:0]         idx_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CAPTURE,
        DONE
    } ldr_state_t;

    function automatic logic in_range(idx_t r, idx_t c);
        return (int'(r) < N) && (int'(c) < N);
    endfunction

endpackage

// File: rtl/mat_mult_loader_if.sv
// Host-side port bundle of the loader: element writes, start,
// result readback and status flags.
interface mat_mult_loader_if;
    import mat_pkg::*;

    logic  wr_en;
    logic  wr_sel;
    idx_t  wr_row;
    idx_t  wr_col;
    elem_t wr_data;
    logic  start;
    idx_t  rd_row;
    idx_t  rd_col;
    elem_t rd_data;
    logic  busy;
    logic  done;
    logic  wr_err;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data,
        output start, rd_row, rd_col,
        input  rd_data, busy, done, wr_err
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data,
        input  start, rd_row, rd_col,
        output rd_data, busy, done, wr_err
    );

endinterface

// File: rtl/mat_buf.sv
// N x N element register file: indexed write, optional full-matrix
// load, registered indexed read returning 0 for out-of-range indices.
module mat_buf
    import mat_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  idx_t  wr_row,
    input  idx_t  wr_col,
    input  elem_t wr_data,
    input  logic  load,
    input  mat_t  ldata,
    input  idx_t  rd_row,
    input  idx_t  rd_col,
    output elem_t rd_data,
    output mat_t  q
);

    mat_t mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem     <= '0;
            rd_data <= '0;
        end else begin
            if (load) begin
                mem <= ldata;
            end else if (we && in_range(wr_row, wr_col)) begin
                mem[wr_row][wr_col] <= wr_data;
            end
            if (in_range(rd_row, rd_col)) begin
                rd_data <= mem[rd_row][rd_col];
            end else begin
                rd_data <= '0;
            end
        end
    end

    assign q = mem;

endmodule

// File: rtl/mat_mult_loader.sv
// Operand feeder and sequencer for the 6x6 matrix multiplier:
// buffers A and B, runs one product, captures the result for readback.
module mat_mult_loader
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    mat_mult_loader_if.slave  host,
    output logic              mm_en,
    output logic              mm_mode,
    output mat_t              mm_dataa,
    output mat_t              mm_datab,
    input  mat_t              mm_result
);

    localparam logic [3:0] RUN_LAST   = 4'(RUN_CYCLES - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    ldr_state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       idle, go, wr_ok, wr_bad, cap;
    logic       wr_err_q;
    elem_t      a_rd, b_rd;
    mat_t       r_q;
    logic       unused_rd;

    assign idle   = (state == IDLE) || (state == DONE);
    assign go     = idle && host.start;
    assign wr_ok  = host.wr_en && idle && in_range(host.wr_row, host.wr_col);
    assign wr_bad = host.wr_en && !wr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mm_en    = 1'b0;
        mm_mode  = 1'b0;
        cap      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (host.start) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                mm_en   = 1'b1;
                mm_mode = 1'b1;
                if (cnt == RUN_LAST) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            DRAIN: begin
                mm_mode = 1'b1;
                if (cnt == DRAIN_LAST) begin
                    state_nx = CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            CAPTURE: begin
                // mode stays high so the multiplier keeps its result
                mm_mode  = 1'b1;
                cap      = 1'b1;
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // an accepted start clears the flag; a same-cycle bad write re-arms it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else if (go) begin
            wr_err_q <= wr_bad;
        end else if (wr_bad) begin
            wr_err_q <= 1'b1;
        end
    end

    assign host.busy   = (state == RUN) || (state == DRAIN) ||
                         (state == CAPTURE);
    assign host.done   = (state == DONE);
    assign host.wr_err = wr_err_q;

    mat_buf u_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_ok && !host.wr_sel),
        .wr_row  (host.wr_row),
        .wr_col  (host.wr_col),
        .wr_data (host.wr_data),
        .load    (1'b0),
        .ldata   ('0),
        .rd_row  (host.rd_row),
        .rd_col  (host.rd_col),
        .rd_data (a_rd),
        .q       (mm_dataa)
    );

    mat_buf u_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_ok && host.wr_sel),
        .wr_row  (host.wr_row),
        .wr_col  (host.wr_col),
        .wr_data (host.wr_data),
        .load    (1'b0),
        .ldata   ('0),
        .rd_row  (host.rd_row),
        .rd_col  (host.rd_col),
        .rd_data (b_rd),
        .q       (mm_datab)
    );

    mat_buf u_res (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (1'b0),
        .wr_row  ('0),
        .wr_col  ('0),
        .wr_data ('0),
        .load    (cap),
        .ldata   (mm_result),
        .rd_row  (host.rd_row),
        .rd_col  (host.rd_col),
        .rd_data (host.rd_data),
        .q       (r_q)
    );

    assign unused_rd = ^{a_rd, b_rd, r_q};

endmodule
